// File: rtl/alu_cmd_pkg.sv
// Shared definitions for the ALU command front-end: FSM states, command bytes
// and ALU function codes (the code list is shared with the ALU itself).
package alu_cmd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GET_A,
    GET_B,
    GET_FUN,
    EXEC,
    WAIT_RES,
    TX_LO,
    TX_HI
  } state_t;

  localparam logic [7:0] CMD_ALU_OPR = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

  localparam logic [3:0] ADD   = 4'd0;
  localparam logic [3:0] SUB   = 4'd1;
  localparam logic [3:0] MUL   = 4'd2;
  localparam logic [3:0] DIV   = 4'd3;
  localparam logic [3:0] AND   = 4'd4;
  localparam logic [3:0] OR    = 4'd5;
  localparam logic [3:0] NAND  = 4'd6;
  localparam logic [3:0] NOR   = 4'd7;
  localparam logic [3:0] XOR   = 4'd8;
  localparam logic [3:0] XNOR  = 4'd9;
  localparam logic [3:0] CMPEQ = 4'd10;
  localparam logic [3:0] CMPGT = 4'd11;
  localparam logic [3:0] CMPLT = 4'd12;
  localparam logic [3:0] SHR   = 4'd13;
  localparam logic [3:0] SHL   = 4'd14;

  // States in which the idle timeout runs.
  function automatic logic is_timed(state_t s);
    return (s == GET_A) || (s == GET_B) || (s == GET_FUN) || (s == WAIT_RES);
  endfunction

endpackage

// File: rtl/alu_cmd_ctrl.sv
// Parses UART command frames into ALU operands/function, pulses alu_en once,
// captures the result and returns it low byte first over valid/ready.
module alu_cmd_ctrl #(
  parameter int DATA_WIDTH     = 8,
  parameter logic [DATA_WIDTH-1:0] CMD_ALU_OPR = alu_cmd_pkg::CMD_ALU_OPR,
  parameter logic [DATA_WIDTH-1:0] CMD_ALU_NOP = alu_cmd_pkg::CMD_ALU_NOP,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DATA_WIDTH-1:0]   rx_data,
  input  logic                    rx_valid,
  output logic [DATA_WIDTH-1:0]   alu_a,
  output logic [DATA_WIDTH-1:0]   alu_b,
  output logic [3:0]              alu_fun,
  output logic                    alu_en,
  input  logic [2*DATA_WIDTH-1:0] alu_out,
  input  logic                    alu_out_valid,
  output logic [DATA_WIDTH-1:0]   tx_data,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  output logic                    busy,
  output logic                    frame_err
);
  import alu_cmd_pkg::*;

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  state_t                  state;
  logic [TW-1:0]           tmo_cnt;
  logic [2*DATA_WIDTH-1:0] result;
  logic                    tmo_hit;

  assign tmo_hit = is_timed(state) && (tmo_cnt == TW'(TIMEOUT_CYCLES));
  assign busy    = (state != IDLE);

  // Driven straight from the result register so the byte cannot move while
  // the transmitter is stalling.
  always_comb begin
    tx_data = '0;
    if (state == TX_LO)
      tx_data = result[DATA_WIDTH-1:0];
    else if (state == TX_HI)
      tx_data = result[2*DATA_WIDTH-1:DATA_WIDTH];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      tmo_cnt   <= '0;
      result    <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_fun   <= '0;
      alu_en    <= 1'b0;
      tx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      alu_en    <= 1'b0;
      frame_err <= 1'b0;
      tmo_cnt   <= is_timed(state) ? tmo_cnt + TW'(1) : '0;

      case (state)
        IDLE: begin
          if (rx_valid && rx_data == CMD_ALU_OPR)
            state <= GET_A;
          else if (rx_valid && rx_data == CMD_ALU_NOP)
            state <= GET_FUN;
        end
        GET_A: begin
          if (tmo_hit) begin
            state     <= IDLE;
            frame_err <= 1'b1;
            tmo_cnt   <= '0;
          end else if (rx_valid) begin
            alu_a   <= rx_data;
            state   <= GET_B;
            tmo_cnt <= '0;
          end
        end
        GET_B: begin
          if (tmo_hit) begin
            state     <= IDLE;
            frame_err <= 1'b1;
            tmo_cnt   <= '0;
          end else if (rx_valid) begin
            alu_b   <= rx_data;
            state   <= GET_FUN;
            tmo_cnt <= '0;
          end
        end
        GET_FUN: begin
          if (tmo_hit) begin
            state     <= IDLE;
            frame_err <= 1'b1;
            tmo_cnt   <= '0;
          end else if (rx_valid) begin
            alu_fun <= rx_data[3:0];
            alu_en  <= 1'b1;
            state   <= EXEC;
            tmo_cnt <= '0;
          end
        end
        EXEC: begin
          if (rx_valid) frame_err <= 1'b1;
          state <= WAIT_RES;
        end
        WAIT_RES: begin
          if (rx_valid) frame_err <= 1'b1;
          if (tmo_hit) begin
            state     <= IDLE;
            frame_err <= 1'b1;
            tmo_cnt   <= '0;
          end else if (alu_out_valid) begin
            result   <= alu_out;
            tx_valid <= 1'b1;
            state    <= TX_LO;
            tmo_cnt  <= '0;
          end
        end
        TX_LO: begin
          if (rx_valid) frame_err <= 1'b1;
          if (tx_ready) state <= TX_HI;
        end
        TX_HI: begin
          if (rx_valid) frame_err <= 1'b1;
          if (tx_ready) begin
            tx_valid <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Directed bench for alu_cmd_ctrl; the bench plays a registered ALU returning
// a scripted result and a UART transmitter with programmable stalls.
module tb_alu_cmd_ctrl;

  logic        clk;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  alu_a, alu_b;
  logic [3:0]  alu_fun;
  logic        alu_en;
  logic [15:0] alu_out;
  logic        alu_out_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic        frame_err;

  int vec  = 0;
  int errs = 0;

  logic [15:0] alu_rsp = 16'h0;
  int en_cnt = 0, ferr_cnt = 0, txv_cnt = 0;
  logic [7:0] last_a = 0, last_b = 0;
  logic [3:0] last_fun = 0;

  alu_cmd_ctrl dut (
    .clk(clk), .reset(reset),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .alu_a(alu_a), .alu_b(alu_b), .alu_fun(alu_fun), .alu_en(alu_en),
    .alu_out(alu_out), .alu_out_valid(alu_out_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .frame_err(frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered ALU stand-in: junk on alu_out except in the valid cycle.
  initial begin
    alu_out       = 16'h0;
    alu_out_valid = 1'b0;
  end
  always @(posedge clk) begin
    alu_out_valid <= alu_en;
    alu_out       <= alu_en ? alu_rsp : 16'hBAD0;
  end

  always @(posedge clk) begin
    if (alu_en) begin
      en_cnt   <= en_cnt + 1;
      last_a   <= alu_a;
      last_b   <= alu_b;
      last_fun <= alu_fun;
    end
    if (frame_err) ferr_cnt <= ferr_cnt + 1;
    if (tx_valid)  txv_cnt  <= txv_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic wait_tx(input string tag);
    int n = 0;
    while (!tx_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_wait"}, tx_valid, 1);
  endtask

  task automatic recv(input string tag, input logic [7:0] exp, input int stall);
    logic [7:0] b;
    wait_tx(tag);
    b = tx_data;
    check({tag, "_data"}, tx_data, exp);
    repeat (stall) begin
      @(negedge clk);
      check({tag, "_hold"}, {tx_valid, tx_data}, {1'b1, b});
    end
    tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;
  endtask

  initial begin
    int e0, f0, t0, n;
    reset    = 1'b0;
    rx_data  = 8'h0;
    rx_valid = 1'b0;
    tx_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_outs", {alu_a, alu_b, alu_fun, alu_en, tx_data, tx_valid, busy, frame_err}, 0);
    reset = 1'b1;
    @(negedge clk);
    check("rst_idle_busy", busy, 0);

    // ADD 05+03, with latency from the FUN byte to tx_valid
    alu_rsp = 16'h0008;
    e0 = en_cnt;
    send_byte(8'hCC); send_byte(8'h05); send_byte(8'h03); send_byte(8'h00);
    check("add_en_hi", {alu_en, tx_valid}, 2'b10);
    @(negedge clk);
    check("add_en_lo", {alu_en, tx_valid}, 2'b00);
    @(negedge clk);
    check("add_txv_lat3", tx_valid, 1);
    recv("add_lo", 8'h08, 0);
    check("add_txv_kept", tx_valid, 1);
    recv("add_hi", 8'h00, 0);
    check("add_busy_done", {busy, tx_valid}, 0);
    check("add_en_pulses", en_cnt - e0, 1);
    check("add_ops", {last_a, last_b, last_fun}, {8'h05, 8'h03, 4'h0});

    // MUL FF*FF with 10-cycle transmitter stalls
    alu_rsp = 16'hFE01;
    send_byte(8'hCC); send_byte(8'hFF); send_byte(8'hFF); send_byte(8'h02);
    recv("mul_lo", 8'h01, 10);
    check("mul_txv_kept", tx_valid, 1);
    recv("mul_hi", 8'hFE, 10);
    check("mul_ops", {last_a, last_b, last_fun}, {8'hFF, 8'hFF, 4'h2});

    // NOP frame reuses stored operands
    alu_rsp = 16'h0000;
    e0 = en_cnt;
    send_byte(8'hDD); send_byte(8'h01);
    recv("sub_lo", 8'h00, 0);
    recv("sub_hi", 8'h00, 0);
    check("sub_ops", {last_a, last_b, last_fun}, {8'hFF, 8'hFF, 4'h1});
    check("sub_en_pulses", en_cnt - e0, 1);

    // CMPGT, FUN byte upper nibble must be ignored
    alu_rsp = 16'hC005;
    send_byte(8'hCC); send_byte(8'h09); send_byte(8'h04); send_byte(8'hFB);
    recv("gt_lo", 8'h05, 3);
    recv("gt_hi", 8'hC0, 0);
    check("gt_ops", {last_a, last_b, last_fun}, {8'h09, 8'h04, 4'hB});

    // Timeout mid-frame
    e0 = en_cnt; f0 = ferr_cnt; t0 = txv_cnt;
    send_byte(8'hCC); send_byte(8'h07);
    n = 0;
    while (!frame_err && n < 1100) begin
      @(negedge clk);
      n++;
    end
    check("tmo_seen", frame_err, 1);
    check("tmo_late_enough", n >= 1000, 1);
    check("tmo_idle", busy, 0);
    repeat (3) @(negedge clk);
    check("tmo_pulse_once", ferr_cnt - f0, 1);
    check("tmo_alu_a", alu_a, 8'h07);
    check("tmo_no_en", en_cnt - e0, 0);
    check("tmo_no_tx", txv_cnt - t0, 0);

    // Byte dropped during a TX_LO stall
    alu_rsp = 16'h1234;
    send_byte(8'hCC); send_byte(8'h01); send_byte(8'h02); send_byte(8'h00);
    wait_tx("drop");
    f0 = ferr_cnt;
    send_byte(8'h33);
    @(negedge clk);
    check("drop_ferr", ferr_cnt - f0, 1);
    check("drop_tx_hold", {tx_valid, tx_data}, {1'b1, 8'h34});
    recv("drop_lo", 8'h34, 2);
    recv("drop_hi", 8'h12, 0);

    // Stray byte in IDLE
    f0 = ferr_cnt;
    send_byte(8'h55);
    repeat (3) @(negedge clk);
    check("stray_ignored", {busy, 8'(ferr_cnt - f0)}, 9'h0);

    // Reset asserted during TX_HI
    alu_rsp = 16'hABCD;
    send_byte(8'hCC); send_byte(8'h01); send_byte(8'h01); send_byte(8'h00);
    recv("rst_mid_lo", 8'hCD, 0);
    check("rst_mid_in_hi", {tx_valid, tx_data}, {1'b1, 8'hAB});
    reset = 1'b0;
    #1;
    check("rst_mid_outs", {alu_a, alu_b, alu_fun, alu_en, tx_data, tx_valid, busy, frame_err}, 0);
    @(negedge clk);
    reset = 1'b1;
    t0 = txv_cnt;
    repeat (3) @(negedge clk);
    check("rst_mid_no_resume", txv_cnt - t0, 0);

    // AND frame after reset
    alu_rsp = 16'h0002;
    send_byte(8'hCC); send_byte(8'h02); send_byte(8'h02); send_byte(8'h04);
    recv("and_lo", 8'h02, 0);
    recv("and_hi", 8'h00, 0);
    check("and_ops", {last_a, last_b, last_fun}, {8'h02, 8'h02, 4'h4});

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule

// File: doc/alu_cmd_ctrl.md
Name: alu_cmd_ctrl

Overview:
- Command front-end that drives the ALU and returns its result.
- Parses byte-wide command frames from the UART receive path and loads operands and function into the ALU.
- Pulses the ALU enable for one cycle, then captures the 2*DATA_WIDTH result.
- Returns the result to the UART transmit path as two bytes, low byte first, using a valid/ready handshake. It sits between the UART RX/TX and the ALU.

Parameters:
- DATA_WIDTH, 8, operand/byte width; ALU result is 2*DATA_WIDTH.
- CMD_ALU_OPR, 8'hCC, command byte for the frame CMD, A, B, FUN.
- CMD_ALU_NOP, 8'hDD, command byte for the frame CMD, FUN, which reuses the stored A and B.
- TIMEOUT_CYCLES, 1024, maximum idle cycles inside a frame or while waiting on the ALU; counter width is $clog2(TIMEOUT_CYCLES+1).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- rx_data  input  DATA_WIDTH  received byte; valid only when rx_valid=1.
- rx_valid  input  1  single-cycle strobe, one per received byte.
- alu_a  output  DATA_WIDTH  operand A, registered, held between commands.
- alu_b  output  DATA_WIDTH  operand B, registered, held between commands.
- alu_fun  output  4  ALU function code, registered.
- alu_en  output  1  ALU enable, exactly one cycle per command.
- alu_out  input  2*DATA_WIDTH  ALU registered result.
- alu_out_valid  input  1  ALU result-valid; high the cycle after alu_en.
- tx_data  output  DATA_WIDTH  byte to transmit.
- tx_valid  output  1  tx_data valid; held until accepted.
- tx_ready  input  1  transmitter accepts when tx_valid&&tx_ready at a rising edge.
- busy  output  1  high in every state except IDLE.
- frame_err  output  1  one-cycle pulse on timeout or on a byte dropped while executing or transmitting.

Behaviour:
- Reset values: all outputs 0, state IDLE, stored operands and result register 0. Reset asserted mid-frame aborts immediately; no partial transmission resumes.
- States: IDLE, GET_A, GET_B, GET_FUN, EXEC, WAIT_RES, TX_LO, TX_HI.
- IDLE:
  - rx_valid with rx_data==CMD_ALU_OPR -> GET_A.
  - rx_valid with rx_data==CMD_ALU_NOP -> GET_FUN.
  - Any other byte is ignored silently, with no frame_err.
- GET_A: rx_valid -> alu_a<=rx_data, then GET_B.
- GET_B: rx_valid -> alu_b<=rx_data, then GET_FUN.
- GET_FUN: rx_valid -> alu_fun<=rx_data[3:0] (upper bits ignored), then EXEC.
- EXEC (1 cycle): alu_en=1 while alu_a, alu_b and alu_fun are stable, then WAIT_RES.
- WAIT_RES: the first cycle with alu_out_valid=1 captures alu_out into the result register and goes to TX_LO. Minimum latency from the FUN byte to tx_valid is 3 cycles.
- TX_LO: tx_valid=1, tx_data=result[DATA_WIDTH-1:0]. On acceptance go to TX_HI; tx_valid stays high across the transition.
- TX_HI: tx_data=result[2*DATA_WIDTH-1:DATA_WIDTH]. On acceptance tx_valid<=0, then IDLE.
- tx_data is stable whenever tx_valid=1 and not yet accepted; tx_ready may be low indefinitely, with no timeout in the TX states.
- Timeout:
  - The counter clears on each state change and on each accepted rx byte.
  - It counts while in GET_A, GET_B, GET_FUN or WAIT_RES.
  - Reaching TIMEOUT_CYCLES forces IDLE and pulses frame_err. Operand registers keep whatever was already loaded.
- rx_valid in EXEC, WAIT_RES, TX_LO or TX_HI: the byte is dropped and frame_err pulses; the state is unaffected.
- rx_valid in the same cycle as a timeout: the timeout wins and the byte is dropped.
- The result register is updated only in WAIT_RES, so a late or spurious alu_out_valid in other states is ignored.
- Function codes are passed through unchecked; the ALU returns 0 for unknown codes and that 0 is transmitted.

Decomposition:
- Shared package alu_cmd_pkg:
  - state enum.
  - command byte constants CMD_ALU_OPR and CMD_ALU_NOP.
  - ALU function code constants ADD=0 .. SHL=14, shared with the ALU.
- Single module; no sub-module. The timeout counter is inline.

Test Plan:
- Frame CC 05 03 00 (ADD) -> alu_en single pulse with A=05 B=03 FUN=0; tx bytes 08 then 00; busy low after the second handshake.
- Frame CC FF FF 02 (MUL) -> result 16'hFE01; tx bytes 01 then FE; tx_ready held low 10 cycles before each accept -> tx_data stable, tx_valid high throughout.
- After the previous frame, DD 01 (SUB, stored A=FF B=FF) -> alu_a and alu_b unchanged, result 0000 sent as 00 00; frame CC 09 04 0B (CMPGT) -> C005, sent as 05 C0.
- CC 07 then silence for TIMEOUT_CYCLES -> frame_err single pulse, IDLE, alu_a=07, no alu_en, no tx_valid.
- rx byte 33 arriving during TX_LO stall -> frame_err pulse, tx bytes unaltered; stray byte 55 in IDLE -> ignored, no frame_err.
- reset deasserted->asserted during TX_HI -> all outputs 0 immediately; next frame CC 02 02 04 (AND) -> tx 02 00.
